// File: rtl/cam_dvp_gen.sv
// DVP camera emulator: divides CLK into PCLK and streams an RGB565 test pattern
// byte-serially with VSYNC/HREF framing, as a physical sensor would.
module cam_dvp_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_FRONT  = 10,
    parameter int PCLK_DIV = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Enable,
    input  logic [1:0]  PatternSel,
    output logic        PCLK,
    output logic        CamVsync,
    output logic        CamHsync,
    output logic [7:0]  CamData,
    output logic        FrameDone,
    output logic [15:0] FrameCount,
    output logic [2:0]  dbg_state
);

    localparam int BPL     = 2 * H_ACTIVE + H_BLANK;
    localparam int BC_W    = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int V_MAX01 = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int V_MAX23 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX   = (V_MAX01 > V_MAX23) ? V_MAX01 : V_MAX23;
    localparam int LC_W    = $clog2(V_MAX + 1);
    localparam int DIV_W   = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_DIV - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BPL - 1);
    localparam logic [31:0]      HREF_END = 32'(2 * H_ACTIVE);
    localparam logic [15:0]      BAR_W    = 16'(H_ACTIVE / 8);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_VFRONT = 3'd4;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [2:0]       state, n_state;
    logic [BC_W-1:0]  bc, n_bc;
    logic [LC_W-1:0]  lc, n_lc;
    logic [1:0]       pat, n_pat;
    logic             frame_end;
    logic             n_vsync, n_hsync;
    logic [7:0]       n_data;

    // Last line index of each vertical region.
    function automatic logic [LC_W-1:0] lines_last(input logic [2:0] s);
        logic [LC_W-1:0] r;
        case (s)
            S_VSYNC:  r = LC_W'(V_SYNC - 1);
            S_VBACK:  r = LC_W'(V_BACK - 1);
            S_ACTIVE: r = LC_W'(V_ACTIVE - 1);
            S_VFRONT: r = LC_W'(V_FRONT - 1);
            default:  r = '0;
        endcase
        return r;
    endfunction

    // Byte for position b of active line l; even b carries the high byte.
    function automatic logic [7:0] pix_byte(input logic [1:0] p_sel,
                                            input logic [BC_W-1:0] b,
                                            input logic [LC_W-1:0] l);
        logic [15:0] x;
        logic [15:0] bar;
        logic [7:0]  y;
        logic [15:0] p;
        x   = 16'(b >> 1);
        y   = 8'(l);
        bar = x / BAR_W;
        case (p_sel)
            2'd0: begin
                case (bar)
                    16'd0:   p = 16'hFFFF;
                    16'd1:   p = 16'hFFE0;
                    16'd2:   p = 16'h07FF;
                    16'd3:   p = 16'h07E0;
                    16'd4:   p = 16'hF81F;
                    16'd5:   p = 16'hF800;
                    16'd6:   p = 16'h001F;
                    default: p = 16'h0000;
                endcase
            end
            2'd1:    p = {y, x[7:0]};
            2'd2:    p = 16'hF800;
            default: p = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
        endcase
        return b[0] ? p[7:0] : p[15:8];
    endfunction

    // PCLK falls on the tick, so outputs registered here are stable at its rise.
    assign tick      = PCLK && (div_cnt == DIV_LAST);
    assign dbg_state = state;

    always_comb begin
        n_state   = state;
        n_bc      = bc;
        n_lc      = lc;
        n_pat     = pat;
        frame_end = 1'b0;
        if (state == S_IDLE) begin
            if (Enable) begin
                n_state = S_VSYNC;
                n_bc    = '0;
                n_lc    = '0;
                n_pat   = PatternSel;
            end
        end else if (bc != BC_LAST) begin
            n_bc = bc + BC_W'(1);
        end else begin
            n_bc = '0;
            if (lc != lines_last(state)) begin
                n_lc = lc + LC_W'(1);
            end else begin
                n_lc = '0;
                case (state)
                    S_VSYNC:  n_state = S_VBACK;
                    S_VBACK:  n_state = S_ACTIVE;
                    S_ACTIVE: n_state = S_VFRONT;
                    S_VFRONT: begin
                        frame_end = 1'b1;
                        if (Enable) begin
                            n_state = S_VSYNC;
                            n_pat   = PatternSel;
                        end else begin
                            n_state = S_IDLE;
                        end
                    end
                    default:  n_state = S_IDLE;
                endcase
            end
        end
    end

    // Outputs describe the byte period that begins with this tick.
    always_comb begin
        n_vsync = (n_state == S_VSYNC);
        n_hsync = (n_state == S_ACTIVE) && (32'(n_bc) < HREF_END);
        n_data  = n_hsync ? pix_byte(n_pat, n_bc, n_lc) : 8'h00;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt    <= '0;
            PCLK       <= 1'b0;
            state      <= S_IDLE;
            bc         <= '0;
            lc         <= '0;
            pat        <= '0;
            CamVsync   <= 1'b0;
            CamHsync   <= 1'b0;
            CamData    <= 8'h00;
            FrameDone  <= 1'b0;
            FrameCount <= 16'h0000;
        end else begin
            FrameDone <= 1'b0;
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                PCLK    <= ~PCLK;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (tick) begin
                state    <= n_state;
                bc       <= n_bc;
                lc       <= n_lc;
                pat      <= n_pat;
                CamVsync <= n_vsync;
                CamHsync <= n_hsync;
                CamData  <= n_data;
                if (frame_end) begin
                    FrameDone  <= 1'b1;
                    FrameCount <= FrameCount + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_dvp_gen.sv
// Bench for cam_dvp_gen in the small configuration: scoreboarded pixel bytes plus
// PCLK, VSYNC, HREF and FrameDone timing checks.
module tb_cam_dvp_gen;

    localparam int H_ACTIVE = 8;
    localparam int H_BLANK  = 4;
    localparam int V_ACTIVE = 4;
    localparam int V_SYNC   = 1;
    localparam int V_BACK   = 1;
    localparam int V_FRONT  = 1;
    localparam int PCLK_DIV = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        Enable = 1'b0;
    logic [1:0]  PatternSel = 2'd0;
    logic        PCLK, CamVsync, CamHsync, FrameDone;
    logic [7:0]  CamData;
    logic [15:0] FrameCount;
    logic [2:0]  dbg_state;

    cam_dvp_gen #(
        .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_FRONT(V_FRONT), .PCLK_DIV(PCLK_DIV)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .Enable(Enable), .PatternSel(PatternSel),
        .PCLK(PCLK), .CamVsync(CamVsync), .CamHsync(CamHsync), .CamData(CamData),
        .FrameDone(FrameDone), .FrameCount(FrameCount), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  exp_q[$];
    int          fd_q[$];
    logic        vs_at_fd[$];
    logic [7:0]  cap [4][16];
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic [7:0]  bar_bytes [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                    8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] outs();
        return {PCLK, CamVsync, CamHsync, CamData, FrameDone, FrameCount};
    endfunction

    function automatic logic [15:0] model_pix(input logic [1:0] pat, input int x, input int y);
        case (pat)
            2'd0:    return bars[x / (H_ACTIVE / 8)];
            2'd1:    return {8'(y), 8'(x)};
            2'd2:    return 16'hF800;
            default: return (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic push_frame(input logic [1:0] pat);
        logic [15:0] p;
        for (int y = 0; y < V_ACTIVE; y++)
            for (int x = 0; x < H_ACTIVE; x++) begin
                p = model_pix(pat, x, y);
                exp_q.push_back(p[15:8]);
                exp_q.push_back(p[7:0]);
            end
    endtask

    // Monitor: samples on the falling CLK edge, far from the DUT's update edge.
    int   cyc = 0;
    logic mon_en = 1'b0;
    logic prev_pclk = 0, prev_vs = 0, prev_hs = 0, prev_fd = 0;
    logic [7:0] prev_data = 0;
    logic have_rise = 0, hs_fall_valid = 0;
    int   last_rise, vs_rise_t, hs_rise_t, hs_fall_t;
    int   vs_rises = 0;
    int   mon_line = 0, mon_bc = 0;

    always @(negedge CLK) begin
        cyc++;
        if (!mon_en) begin
            have_rise     = 0;
            hs_fall_valid = 0;
        end else begin
            if (!prev_pclk && PCLK) begin
                if (have_rise) chk("pclk_period", cyc - last_rise, 2 * PCLK_DIV);
                have_rise = 1;
                last_rise = cyc;
                if (CamHsync) begin
                    if (exp_q.size() == 0) chk("exp_underflow", 1, 0);
                    else chk("data", CamData, exp_q.pop_front());
                    if (mon_line < 4 && mon_bc < 16) cap[mon_line][mon_bc] = CamData;
                    mon_bc++;
                end else begin
                    chk("blank_data", CamData, 0);
                end
            end
            if ({CamVsync, CamHsync, CamData} != {prev_vs, prev_hs, prev_data})
                chk("change_off_tick", {prev_pclk, PCLK}, 2'b10);
            if (CamVsync && !prev_vs) begin
                vs_rise_t = cyc;
                vs_rises++;
                mon_line = 0;
            end
            if (!CamVsync && prev_vs) chk("vsync_len", cyc - vs_rise_t, 80);
            if (CamHsync && !prev_hs) begin
                if (hs_fall_valid) chk("hsync_gap", cyc - hs_fall_t, 16);
                hs_rise_t = cyc;
                mon_bc = 0;
            end
            if (!CamHsync && prev_hs) begin
                chk("hsync_len", cyc - hs_rise_t, 64);
                hs_fall_t = cyc;
                hs_fall_valid = (mon_line < V_ACTIVE - 1);
                mon_line++;
            end
            if (FrameDone) begin
                if (prev_fd) chk("fd_width", 2, 1);
                else begin
                    fd_q.push_back(cyc);
                    vs_at_fd.push_back(CamVsync);
                end
            end
        end
        prev_pclk = PCLK;
        prev_vs   = CamVsync;
        prev_hs   = CamHsync;
        prev_data = CamData;
        prev_fd   = FrameDone;
    end

    task automatic do_reset();
        mon_en = 0;
        Enable = 0;
        RST_N  = 0;
        repeat (3) @(negedge CLK);
        chk("rst_held", outs(), 0);
        exp_q.delete();
        fd_q.delete();
        vs_at_fd.delete();
        RST_N = 1;
        @(negedge CLK);
        chk("rst_vals", outs(), 0);
        chk("rst_state", dbg_state, 0);
        mon_en = 1;
    endtask

    // Runs n back-to-back frames, dropping Enable once the last one has started.
    task automatic run_frames(input logic [1:0] pat, input int n);
        int vs0, fd0, t;
        vs0 = vs_rises;
        fd0 = fd_q.size();
        PatternSel = pat;
        Enable = 1;
        for (int k = 0; k < n; k++) push_frame(pat);
        t = 0;
        while (vs_rises < vs0 + n && t < n * 700 + 200) begin @(negedge CLK); t++; end
        chk("vsync_timeout", vs_rises - vs0, n);
        Enable = 0;
        t = 0;
        while (fd_q.size() < fd0 + n && t < 1400) begin @(negedge CLK); t++; end
        chk("fd_timeout", fd_q.size() - fd0, n);
        repeat (100) @(negedge CLK);
        chk("exp_drained", exp_q.size(), 0);
        chk("idle_outs", {CamVsync, CamHsync, CamData}, 0);
    endtask

    initial begin
        int t, vs0;

        // 1: solid red, single frame
        do_reset();
        run_frames(2'd2, 1);
        chk("t1_count", FrameCount, 1);
        chk("t1_hi", cap[3][0], 8'hF8);
        chk("t1_lo", cap[3][15], 8'h00);

        // 2: colour bars
        do_reset();
        run_frames(2'd0, 1);
        for (int i = 0; i < 16; i++) chk("t2_bars", cap[1][i], bar_bytes[i]);

        // 3: ramp
        do_reset();
        run_frames(2'd1, 1);
        chk("t3_l2p5_hi", cap[2][10], 8'h02);
        chk("t3_l2p5_lo", cap[2][11], 8'h05);
        for (int y = 0; y < V_ACTIVE; y++)
            for (int x = 0; x < H_ACTIVE; x++) begin
                chk("t3_ramp_hi", cap[y][2 * x], 8'(y));
                chk("t3_ramp_lo", cap[y][2 * x + 1], 8'(x));
            end

        // 4: three frames back to back
        do_reset();
        run_frames(2'd0, 3);
        chk("t4_count", FrameCount, 3);
        chk("t4_nfd", fd_q.size(), 3);
        if (fd_q.size() == 3) begin
            chk("t4_space1", fd_q[1] - fd_q[0], 560);
            chk("t4_space2", fd_q[2] - fd_q[1], 560);
            chk("t4_vs_fd0", vs_at_fd[0], 1);
            chk("t4_vs_fd1", vs_at_fd[1], 1);
            chk("t4_vs_fd2", vs_at_fd[2], 0);
        end

        // 5: Enable and PatternSel change mid-frame
        do_reset();
        PatternSel = 2'd3;
        Enable = 1;
        push_frame(2'd3);
        t = 0;
        while (!(mon_line == 1 && CamHsync) && t < 1500) begin @(negedge CLK); t++; end
        chk("t5_reach_l1", (mon_line == 1 && CamHsync), 1);
        Enable = 0;
        PatternSel = 2'd1;
        t = 0;
        while (fd_q.size() < 1 && t < 1000) begin @(negedge CLK); t++; end
        chk("t5_fd", fd_q.size(), 1);
        vs0 = vs_rises;
        repeat (700) @(negedge CLK);
        chk("t5_no_restart", vs_rises - vs0, 0);
        chk("t5_nfd", fd_q.size(), 1);
        chk("t5_count", FrameCount, 1);
        chk("t5_drained", exp_q.size(), 0);
        chk("t5_idle", {CamVsync, CamHsync, CamData}, 0);

        // 6: asynchronous reset during ACTIVE
        PatternSel = 2'd0;
        Enable = 1;
        push_frame(2'd0);
        t = 0;
        while (!(mon_line == 1 && CamHsync) && t < 1500) begin @(negedge CLK); t++; end
        chk("t6_reach_l1", (mon_line == 1 && CamHsync), 1);
        mon_en = 0;
        #2 RST_N = 0;
        #1 chk("t6_async_rst", outs(), 0);
        do_reset();
        run_frames(2'd0, 1);
        chk("t6_count", FrameCount, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
